// File: rtl/mdu_pkg.sv
// Shared HI/LO unit definitions: op encodings, FSM states,
// default latencies and a small sign helper.
package mdu_pkg;

  localparam int MUL_CYCLES_DEF = 3;
  localparam int DIV_CYCLES_DEF = 33;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  function automatic logic [31:0] neg_if(
    input logic        n,
    input logic [31:0] v
  );
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// 32-step restoring unsigned divider; loads on start,
// then retires one quotient bit per clock.
module div_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic        run;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  assign rem_sh    = {rem, quo[31]};
  assign diff      = rem_sh - {1'b0, dvs};
  assign quotient  = quo;
  assign remainder = rem;

  always_ff @(posedge clock) begin
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
      cnt <= '0;
      run <= 1'b1;
    end else if (flush) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (run) begin
      if (!diff[32]) begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= rem_sh[31:0];
        quo <= {quo[30:0], 1'b0};
      end
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) run <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide controller: owns HI/LO, sequences
// multi-cycle MULT/DIV and raises pipeline stall.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        hilo_rd,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        div_zero
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES - 1);

  md_state_t   state;
  md_state_t   state_nx;
  md_op_t      op;
  logic [5:0]  cnt;
  logic [63:0] prod;
  logic        q_neg;
  logic        r_neg;
  logic        is_mul;
  logic        is_div;
  logic        is_sgn;
  logic        is_mthi;
  logic        is_mtlo;
  logic        take;
  logic        div_start;
  logic        commit;
  logic [31:0] quo;
  logic [31:0] rem;

  assign op        = md_op_t'(md_op);
  assign take      = (state == ST_IDLE) & md_valid & ~flush;
  assign busy      = (state != ST_IDLE);
  assign stall     = busy & (md_valid | hilo_rd);
  assign div_start = take & is_div & (op2 != 32'd0);
  assign done      = commit & ~reset;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_sgn  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (1'b1)
      op == OP_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
      op == OP_MULTU: is_mul = 1'b1;
      op == OP_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
      op == OP_DIVU:  is_div = 1'b1;
      op == OP_MTHI:  is_mthi = 1'b1;
      op == OP_MTLO:  is_mtlo = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (take && is_mul) state_nx = ST_MUL;
        else if (div_start) state_nx = ST_DIV;
      end
      ST_MUL: begin
        if (flush) begin
          state_nx = ST_IDLE;
        end else if (cnt == MUL_LAST) begin
          state_nx = ST_IDLE;
          commit   = 1'b1;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_nx = ST_IDLE;
        end else if (cnt == DIV_LAST) begin
          state_nx = ST_IDLE;
          commit   = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // divider sees magnitudes; signs are re-applied in the last cycle
  div_iter u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .flush     (flush),
    .dividend  (neg_if(is_sgn & op1[31], op1)),
    .divisor   (neg_if(is_sgn & op2[31], op2)),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      prod     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      div_zero <= take & is_div & (op2 == 32'd0);
      cnt <= (busy && state_nx == state) ? cnt + 6'd1 : 6'd0;
      if (take) begin
        if (is_mul && is_sgn)
          prod <= $signed({{32{op1[31]}}, op1})
                * $signed({{32{op2[31]}}, op2});
        else if (is_mul)
          prod <= {32'd0, op1} * {32'd0, op2};
        if (is_div) begin
          q_neg <= is_sgn & (op1[31] ^ op2[31]);
          r_neg <= is_sgn & op1[31];
        end
        if (is_mthi) hi <= op1;
        if (is_mtlo) lo <= op1;
      end
      if (commit && state == ST_MUL) begin
        {hi, lo} <= prod;
      end else if (commit) begin
        lo <= neg_if(q_neg, quo);
        hi <= neg_if(r_neg, rem);
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus
// random ops against an arithmetic HI/LO model.
module tb_mdu_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        md_valid;
  logic [2:0]  md_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        hilo_rd;
  logic        flush;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  always #5 clock = ~clock;

  mdu_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .md_valid (md_valid),
    .md_op    (md_op),
    .op1      (op1),
    .op2      (op2),
    .hilo_rd  (hilo_rd),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted op, from plain arithmetic.
  function automatic void ref_op(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    inout  logic [31:0] h,
    inout  logic [31:0] l,
    output int          lat,
    output bit          dz
  );
    longint      sa = $signed(a);
    longint      sb = $signed(b);
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    logic [63:0] p;
    lat = 0;
    dz  = 0;
    case (op)
      3'd1: begin p = 64'(sa * sb); {h, l} = p; lat = 3; end
      3'd2: begin p = ua * ub; {h, l} = p; lat = 3; end
      3'd3: begin
        if (b == 0) dz = 1;
        else begin l = 32'(sa / sb); h = 32'(sa % sb); lat = 33; end
      end
      3'd4: begin
        if (b == 0) dz = 1;
        else begin l = a / b; h = a % b; lat = 33; end
      end
      3'd5: h = a;
      3'd6: l = a;
      default: ;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    logic [31:0] nh;
    logic [31:0] nl;
    int lat;
    bit dz;
    int n;
    int done_at;
    int dn;
    bit clean;
    nh = hi_m;
    nl = lo_m;
    ref_op(op, a, b, nh, nl, lat, dz);
    md_valid = 1'b1;
    md_op = op;
    op1 = a;
    op2 = b;
    tick();
    md_valid = 1'b0;
    md_op = 3'd0;
    op1 = $urandom;
    op2 = $urandom;
    chk({tag, ".dz"}, 64'(div_zero), 64'(dz));
    if (lat == 0) begin
      hi_m = nh;
      lo_m = nl;
    end
    n = 0;
    done_at = -1;
    dn = 0;
    clean = 1;
    while (busy === 1'b1 && n < 200) begin
      if (hi !== hi_m || lo !== lo_m) clean = 0;
      if (done === 1'b1) begin
        dn++;
        done_at = n;
      end
      n++;
      tick();
    end
    hi_m = nh;
    lo_m = nl;
    chk({tag, ".busy_cycles"}, 64'(n), 64'(lat));
    chk({tag, ".done_cnt"}, 64'(dn), 64'(lat == 0 ? 0 : 1));
    chk({tag, ".done_at"}, 64'(done_at), 64'(lat - 1));
    chk({tag, ".no_partial"}, 64'(clean), 64'd1);
    chk({tag, ".hi"}, 64'(hi), 64'(hi_m));
    chk({tag, ".lo"}, 64'(lo), 64'(lo_m));
  endtask

  initial begin
    int bad;
    bit seen_done;
    reset    = 1'b1;
    md_valid = 1'b1;
    md_op    = 3'd1;
    op1      = 32'd5;
    op2      = 32'd5;
    hilo_rd  = 1'b1;
    flush    = 1'b0;
    tick();
    tick();
    chk("rst.stall", 64'(stall), 64'd0);
    md_valid = 1'b0;
    md_op = 3'd0;
    hilo_rd = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.dz", 64'(div_zero), 64'd0);
    tick();

    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult");
    chk("mult.hi_abs", 64'(hi), 64'hFFFF_FFFF);
    chk("mult.lo_abs", 64'(lo), 64'hFFFF_FFFA);
    do_op(3'd2, 32'hFFFF_FFFE, 32'd3, "multu");
    chk("multu.hi_abs", 64'(hi), 64'h2);
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div");
    chk("div.lo_abs", 64'(lo), 64'hFFFF_FFFD);
    chk("div.hi_abs", 64'(hi), 64'hFFFF_FFFF);
    do_op(3'd4, 32'd7, 32'd2, "divu");
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf.lo_abs", 64'(lo), 64'h8000_0000);

    do_op(3'd5, 32'h11, 32'd0, "mthi");
    do_op(3'd6, 32'h22, 32'd0, "mtlo");
    do_op(3'd3, 32'd99, 32'd0, "divz");
    tick();
    chk("divz.pulse_end", 64'(div_zero), 64'd0);
    chk("divz.hi", 64'(hi), 64'h11);

    do_op(3'd5, 32'hDEAD_BEEF, 32'd0, "b2b_mthi");
    chk("b2b.hi_now", 64'(hi), 64'hDEAD_BEEF);
    do_op(3'd1, 32'd2, 32'd3, "b2b_mult");
    chk("b2b.lo6", 64'(lo), 64'd6);
    do_op(3'd7, 32'h55, 32'h55, "rsvd");
    do_op(3'd0, 32'h55, 32'h55, "none");

    // Flush and md_valid together in IDLE: nothing accepted.
    md_valid = 1'b1;
    md_op = 3'd5;
    op1 = 32'h999;
    flush = 1'b1;
    tick();
    md_op = 3'd1;
    tick();
    md_valid = 1'b0;
    flush = 1'b0;
    chk("idle_flush.hi", 64'(hi), 64'(hi_m));
    chk("idle_flush.busy", 64'(busy), 64'd0);

    // DIV: MF* read from cycle 5 stalls; squash at cycle 10.
    md_valid = 1'b1;
    md_op = 3'd3;
    op1 = 32'd1000;
    op2 = 32'd7;
    tick();
    md_valid = 1'b0;
    bad = 0;
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) hilo_rd = 1'b1;
      #1;
      if (stall !== (c >= 5)) bad++;
      if (busy !== 1'b1) bad++;
      if (done === 1'b1) seen_done = 1;
      tick();
    end
    flush = 1'b1;
    #1;
    chk("sq.stall", 64'(stall), 64'd1);
    chk("sq.done", 64'(done), 64'd0);
    tick();
    flush = 1'b0;
    hilo_rd = 1'b0;
    chk("sq.bad", 64'(bad), 64'd0);
    chk("sq.seen_done", 64'(seen_done), 64'd0);
    chk("sq.busy", 64'(busy), 64'd0);
    chk("sq.hi", 64'(hi), 64'(hi_m));
    chk("sq.lo", 64'(lo), 64'(lo_m));

    // Flush on the final MUL cycle beats the write.
    md_valid = 1'b1;
    md_op = 3'd2;
    op1 = 32'd9;
    op2 = 32'd9;
    tick();
    md_valid = 1'b0;
    tick();
    tick();
    chk("lastfl.done_pre", 64'(done), 64'd1);
    flush = 1'b1;
    #1;
    chk("lastfl.done", 64'(done), 64'd0);
    tick();
    flush = 1'b0;
    chk("lastfl.busy", 64'(busy), 64'd0);
    chk("lastfl.lo", 64'(lo), 64'(lo_m));

    // Op presented while busy stalls, then issues when idle.
    md_valid = 1'b1;
    md_op = 3'd1;
    op1 = 32'd5;
    op2 = 32'd7;
    tick();
    md_op = 3'd6;
    op1 = 32'h1234;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (stall !== 1'b1) bad++;
      tick();
    end
    chk("hold.stall", 64'(bad), 64'd0);
    chk("hold.busy", 64'(busy), 64'd0);
    chk("hold.lo_mul", 64'(lo), 64'd35);
    chk("hold.hi_mul", 64'(hi), 64'd0);
    tick();
    md_valid = 1'b0;
    chk("hold.lo_mtlo", 64'(lo), 64'h1234);
    hi_m = 32'd0;
    lo_m = 32'h1234;

    // Reset 20 cycles into a DIV.
    do_op(3'd5, 32'h55, 32'd0, "pre_rst");
    md_valid = 1'b1;
    md_op = 3'd4;
    op1 = 32'd1000;
    op2 = 32'd3;
    tick();
    md_valid = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    reset = 1'b1;
    #1;
    chk("mrst.done_in", 64'(done), 64'd0);
    tick();
    reset = 1'b0;
    chk("mrst.hi", 64'(hi), 64'd0);
    chk("mrst.lo", 64'(lo), 64'd0);
    chk("mrst.busy", 64'(busy), 64'd0);
    chk("mrst.done", 64'(done), 64'd0);
    hi_m = '0;
    lo_m = '0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    chk("mrst.quiet", 64'(bad), 64'd0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 3'($urandom_range(1, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) rb = ~rb;
      do_op(rop, ra, rb, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
